// File: rtl/paint_pkg.sv
// Shared screen geometry, widths and the pixel word carried from the clip stage
// through the FIFO to the framebuffer port.
package paint_pkg;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 11;
  localparam int COLOR_W = 8;
  localparam int ADDR_W  = 19;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } pixel_t;

  // Row-major linear framebuffer address; exact for every on-screen coordinate.
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [COORD_W-1:0] px,
                                                 input logic [COORD_W-1:0] py);
    return ADDR_W'(py) * ADDR_W'(H_RES) + ADDR_W'(px);
  endfunction
endpackage

// File: rtl/pixel_writer_if.sv
// Framebuffer write port between the pixel writer (master) and memory (slave).
interface pixel_writer_if;
  import paint_pkg::*;

  // Handshake: a write transfers on every rising edge where mem_valid and
  // mem_ready are both high; once mem_valid rises, mem_addr/mem_data stay
  // stable and mem_valid stays high until that transfer happens.
  logic               mem_valid;
  logic               mem_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_data;

  modport master (output mem_valid, output mem_addr, output mem_data, input mem_ready);
  modport slave  (input mem_valid, input mem_addr, input mem_data, output mem_ready);
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO of pixel words; head is valid whenever not empty.
module pixel_fifo
  import paint_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  pixel_t                     push_data,
  input  logic                       pop,
  output pixel_t                     head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  pixel_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the same edge frees the head slot.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/pixel_writer.sv
// Pixel stream sink: clips to the screen, linearises (x,y), and queues writes so
// the drawing engines never see framebuffer stalls.
module pixel_writer
  import paint_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       plot,
  input  logic [COORD_W-1:0]         x,
  input  logic [COORD_W-1:0]         y,
  input  logic [COLOR_W-1:0]         color,
  input  logic                       clear_err,
  pixel_writer_if.master             mem,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow,
  output logic                       clipped,
  output logic                       idle
);
  logic   on_screen;
  logic   s1_valid;
  pixel_t s1_pix;
  pixel_t head;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   push;
  logic   drop;
  logic   clip_hit;

  assign on_screen = (x < COORD_W'(H_RES)) && (y < COORD_W'(V_RES));
  assign clip_hit  = plot && !on_screen;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= plot && on_screen;
    end
    if (plot) begin
      s1_pix.addr <= lin_addr(x, y);
      s1_pix.data <= color;
    end
  end

  assign pop  = mem.mem_valid && mem.mem_ready;
  assign push = s1_valid && (!fifo_full || pop);
  assign drop = s1_valid && fifo_full && !pop;

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (s1_pix),
    .pop       (pop),
    .head      (head),
    .count     (fill_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign mem.mem_valid = !fifo_empty;
  assign mem.mem_addr  = head.addr;
  assign mem.mem_data  = head.data;

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      clipped  <= 1'b0;
    end else begin
      overflow <= drop     || (overflow && !clear_err);
      clipped  <= clip_hit || (clipped  && !clear_err);
    end
  end

  assign idle = !plot && !s1_valid && fifo_empty;
endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Sink end of the drawing-engine pixel stream: consumes the one-pixel-per-cycle plot/x/y output of the line and shape engines. Those engines have no backpressure.
- Clips each pixel to the screen and converts (x,y) to a linear framebuffer address.
- Buffers accepted pixels in a FIFO and issues them to the framebuffer memory port over a valid/ready handshake.
- Absorbs memory stalls so drawing engines never have to wait.

Parameters:
- H_RES, 640, visible width in pixels; x >= H_RES is off-screen
- V_RES, 480, visible height in pixels; y >= V_RES is off-screen
- COLOR_W, 8, pixel data width
- ADDR_W, 19, framebuffer word address width; must satisfy H_RES*V_RES <= 2**ADDR_W
- DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- plot  in  1  pixel strobe; one pixel per cycle when high, no ready returned
- x  in  11  pixel column, unsigned
- y  in  11  pixel row, unsigned
- color  in  COLOR_W  pixel value, sampled with plot
- clear_err  in  1  clears the sticky overflow and clipped flags
- mem_valid  out  1  write request to framebuffer
- mem_ready  in  1  framebuffer accepts the request this cycle
- mem_addr  out  ADDR_W  write address = y*H_RES + x
- mem_data  out  COLOR_W  write data
- fill_level  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- clipped  out  1  sticky: an off-screen pixel was discarded
- idle  out  1  no pixel in flight anywhere in the block

Behaviour:
- Reset (synchronous, active-high):
  - Clears the stage-1 register and the FIFO pointers and count.
  - Reset values: mem_valid=0, fill_level=0, overflow=0, clipped=0, idle=1.
  - mem_addr and mem_data are don't-care while mem_valid=0.
  - Reset mid-burst discards all queued pixels; no partial write is issued after reset.
- Stage 1 (clip + address, registered):
  - On plot=1 with x<H_RES and y<V_RES: s1_valid<=1, s1_addr<=y*H_RES+x (computed at ADDR_W, no truncation for in-range inputs), s1_data<=color.
  - On plot=1 off-screen: s1_valid<=0 and clipped<=1.
  - On plot=0: s1_valid<=0.
- Stage 2 (FIFO push):
  - If s1_valid and (count<DEPTH or a pop occurs this cycle), push {s1_addr, s1_data}.
  - If s1_valid and count==DEPTH and no pop: drop the pixel and set overflow<=1.
  - Push while full is allowed only when a simultaneous pop frees a slot.
- FIFO output (show-ahead):
  - mem_valid = (count != 0); mem_addr/mem_data = head entry.
  - Pop when mem_valid && mem_ready.
  - While mem_valid=1 and mem_ready=0, mem_addr and mem_data hold stable.
  - Pixels are written in plot order.
- Latency: plot in cycle N -> mem_valid with that pixel's address in cycle N+2 at the earliest (FIFO empty, registered FIFO output count).
- Throughput: sustained one pixel per cycle when mem_ready is held high.
- fill_level: registered count. It changes +1 on push-only, -1 on pop-only, and is unchanged on simultaneous push and pop.
- Flags:
  - clear_err=1 clears overflow and clipped.
  - If a set event occurs in the same cycle as clear_err, the set wins.
- idle = !plot && !s1_valid && (count==0). Engines and the top-level controller use it to detect that a drawn shape is fully committed to memory.
- Wrap: FIFO pointers are log2(DEPTH) bits and wrap naturally; the count distinguishes full from empty.
- No state machine beyond the FIFO, since the block is purely flow-through.

Decomposition:
- paint_pkg holds H_RES, V_RES, COORD_W=11, COLOR_W, ADDR_W, and typedef pixel_t {logic [ADDR_W-1:0] addr; logic [COLOR_W-1:0] data;}.
- One sub-module, pixel_fifo: a synchronous show-ahead FIFO of pixel_t with push/pop/count/full/empty, parameterised by DEPTH.
- pixel_writer holds stage 1, the flags, idle, and the pixel_fifo instance.

Test Plan:
- Single pixel: mem_ready=1, plot one cycle with x=3, y=2, color=8'h5A -> exactly one mem_valid cycle at N+2 with mem_addr=1283 and mem_data=8'h5A; idle=1 afterwards.
- Clipping: plot with x=640,y=0, then x=0,y=480, then x=639,y=479 -> only one write, at mem_addr=307199; clipped=1; clear_err -> clipped=0.
- Overflow: mem_ready=0, 20 consecutive plots at x=0..19, y=0 -> fill_level=16 and overflow=1; then mem_ready=1 -> addresses 0..15 written in order, x=16..19 lost.
- Backpressure stability: queue 3 pixels, toggle mem_ready 0/1 on alternate cycles -> mem_addr/mem_data never change while valid&&!ready; exactly 3 handshakes, in order.
- Full with simultaneous pop: fill the FIFO to 16, then assert mem_ready=1 in the same cycle a new in-range pixel arrives at stage 2 -> pixel is accepted, fill_level stays 16, overflow stays 0.
- Reset mid-burst: 8 pixels queued, assert reset one cycle -> next cycle mem_valid=0, fill_level=0, overflow=0, idle=1; no stale writes appear afterwards.
